// File: rtl/pcm_pkg.sv
// Shared PCM definitions: scheduler FSM states, requester indices and the
// MODE=0 bank decode used by both the scheduler and the PCM address path.
package pcm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_WAIT = 2'd2,
    ST_CAPT = 2'd3
  } pcm_state_t;

  localparam logic PORT_RA = 1'b0;
  localparam logic PORT_PA = 1'b1;

  // One-hot-low chip select for the four 1 MiB banks.
  function automatic logic [3:0] bank_decode(input logic [1:0] sel);
    logic [3:0] cs;
    case (sel)
      2'd0:    cs = 4'b1110;
      2'd1:    cs = 4'b1101;
      2'd2:    cs = 4'b1011;
      2'd3:    cs = 4'b0111;
      default: cs = 4'b1111;
    endcase
    return cs;
  endfunction

  function automatic logic [23:0] map_addr(input logic mode, input logic [23:0] addr);
    logic [23:0] a;
    if (mode) begin
      a = addr;
    end else begin
      a = {bank_decode(addr[21:20]), addr[19:0]};
    end
    return a;
  endfunction

endpackage

// File: rtl/pcm_rom_sched_if.sv
// External V-ROM bus shared by the PCM requesters.
interface pcm_rom_sched_if;
  logic [23:0] ROM_A;
  logic        nROM_OE;
  logic [7:0]  ROM_D;

  modport master (output ROM_A, output nROM_OE, input ROM_D);
  modport slave  (input ROM_A, input nROM_OE, output ROM_D);
endinterface

// File: rtl/pcm_req_slot.sv
// One-deep request slot: latches a strobed address until granted and flags
// strobes that arrive while a request is still waiting.
module pcm_req_slot (
  input  logic        CLK_68KCLKB,
  input  logic        nRESET,
  input  logic        stb,
  input  logic [23:0] addr,
  input  logic        grant,
  output logic        pend,
  output logic [23:0] pend_addr,
  output logic        ovr
);

  logic        pend_r;
  logic [23:0] addr_r;
  logic        ovr_r;

  // Pending flag, address latch and sticky overrun.
  always_ff @(posedge CLK_68KCLKB or negedge nRESET) begin
    if (!nRESET) begin
      pend_r <= 1'b0;
      addr_r <= 24'h000000;
      ovr_r  <= 1'b0;
    end else if (grant) begin
      // A strobe on the grant edge refills the slot immediately.
      pend_r <= stb;
      if (stb) begin
        addr_r <= addr;
      end
    end else if (stb) begin
      if (pend_r) begin
        ovr_r <= 1'b1;
      end else begin
        pend_r <= 1'b1;
        addr_r <= addr;
      end
    end
  end

  assign pend      = pend_r;
  assign pend_addr = addr_r;
  assign ovr       = ovr_r;

endmodule

// File: rtl/pcm_rom_sched.sv
// Round-robin scheduler sharing the sample ROM between ADPCM-A and ADPCM-B.
// Each access: ADDR setup cycle, WAIT_CYC cycles of nROM_OE low, then capture.
module pcm_rom_sched
  import pcm_pkg::*;
#(
  parameter int WAIT_CYC = 2
) (
  input  logic                   CLK_68KCLKB,
  input  logic                   nRESET,
  input  logic                   RA_STB,
  input  logic [23:0]            RA_ADDR,
  input  logic                   PA_STB,
  input  logic [23:0]            PA_ADDR,
  input  logic                   MODE,
  pcm_rom_sched_if.master        rom,
  output logic                   RA_ACK,
  output logic                   PA_ACK,
  output logic [7:0]             RA_DATA,
  output logic [7:0]             PA_DATA,
  output logic                   RA_OVR,
  output logic                   PA_OVR,
  output logic                   BUSY
);

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYC - 1);

  pcm_state_t  state_r, state_s;
  logic        last_r, gnt_port_r;
  logic [3:0]  cnt_r;
  logic [23:0] rom_a_r;
  logic        oe_n_r, ra_ack_r, pa_ack_r, busy_r;
  logic [7:0]  ra_data_r, pa_data_r;

  logic        ra_pend_s, pa_pend_s;
  logic [23:0] ra_addr_s, pa_addr_s;
  logic        sel_pa_s, grant_en_s, ra_grant_s, pa_grant_s, wait_done_s;

  pcm_req_slot u_slot_ra (
    .CLK_68KCLKB (CLK_68KCLKB), .nRESET (nRESET), .stb (RA_STB), .addr (RA_ADDR),
    .grant (ra_grant_s), .pend (ra_pend_s), .pend_addr (ra_addr_s), .ovr (RA_OVR)
  );

  pcm_req_slot u_slot_pa (
    .CLK_68KCLKB (CLK_68KCLKB), .nRESET (nRESET), .stb (PA_STB), .addr (PA_ADDR),
    .grant (pa_grant_s), .pend (pa_pend_s), .pend_addr (pa_addr_s), .ovr (PA_OVR)
  );

  // Arbitration: PA wins only if alone or if RA was served last.
  always_comb begin
    sel_pa_s    = pa_pend_s & (~ra_pend_s | (last_r == PORT_RA));
    grant_en_s  = (ra_pend_s | pa_pend_s) & ((state_r == ST_IDLE) | (state_r == ST_CAPT));
    ra_grant_s  = grant_en_s & ~sel_pa_s;
    pa_grant_s  = grant_en_s & sel_pa_s;
    wait_done_s = (state_r == ST_WAIT) && (cnt_r == 4'd0);
  end

  // Next-state logic; CAPT chains straight into ADDR under demand.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: state_s = grant_en_s ? ST_ADDR : ST_IDLE;
      ST_ADDR: state_s = ST_WAIT;
      ST_WAIT: state_s = wait_done_s ? ST_CAPT : ST_WAIT;
      ST_CAPT: state_s = grant_en_s ? ST_ADDR : ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State, grant bookkeeping, wait counter and registered bus outputs.
  always_ff @(posedge CLK_68KCLKB or negedge nRESET) begin
    if (!nRESET) begin
      state_r    <= ST_IDLE;
      last_r     <= PORT_PA;
      gnt_port_r <= PORT_RA;
      cnt_r      <= 4'd0;
      rom_a_r    <= 24'h000000;
      oe_n_r     <= 1'b1;
      busy_r     <= 1'b0;
    end else begin
      state_r <= state_s;
      if (grant_en_s) begin
        last_r     <= sel_pa_s;
        gnt_port_r <= sel_pa_s;
        rom_a_r    <= map_addr(MODE, sel_pa_s ? pa_addr_s : ra_addr_s);
      end
      if (state_r == ST_ADDR) begin
        cnt_r <= WAIT_LD;
      end else if ((state_r == ST_WAIT) && (cnt_r != 4'd0)) begin
        cnt_r <= cnt_r - 4'd1;
      end
      oe_n_r <= (state_s != ST_WAIT);
      busy_r <= (state_s != ST_IDLE);
    end
  end

  // Data capture and done pulses for the granted port only.
  always_ff @(posedge CLK_68KCLKB or negedge nRESET) begin
    if (!nRESET) begin
      ra_ack_r  <= 1'b0;
      pa_ack_r  <= 1'b0;
      ra_data_r <= 8'h00;
      pa_data_r <= 8'h00;
    end else begin
      ra_ack_r <= wait_done_s & (gnt_port_r == PORT_RA);
      pa_ack_r <= wait_done_s & (gnt_port_r == PORT_PA);
      if (wait_done_s && (gnt_port_r == PORT_RA)) begin
        ra_data_r <= rom.ROM_D;
      end
      if (wait_done_s && (gnt_port_r == PORT_PA)) begin
        pa_data_r <= rom.ROM_D;
      end
    end
  end

  assign rom.ROM_A   = rom_a_r;
  assign rom.nROM_OE = oe_n_r;
  assign RA_ACK      = ra_ack_r;
  assign PA_ACK      = pa_ack_r;
  assign RA_DATA     = ra_data_r;
  assign PA_DATA     = pa_data_r;
  assign BUSY        = busy_r;

endmodule

// File: tb/tb_pcm_rom_sched.sv
// Directed bench for pcm_rom_sched with WAIT_CYC=2; expected values are
// hand-derived from the access timeline (ACK at strobe edge + 4).
module tb_pcm_rom_sched;

  logic        CLK_68KCLKB = 1'b0;
  logic        nRESET;
  logic        RA_STB, PA_STB, MODE;
  logic [23:0] RA_ADDR, PA_ADDR;
  logic        RA_ACK, PA_ACK, RA_OVR, PA_OVR, BUSY;
  logic [7:0]  RA_DATA, PA_DATA;

  int n_cmp = 0;
  int n_bad = 0;

  pcm_rom_sched_if rom_bus ();

  pcm_rom_sched #(.WAIT_CYC(2)) dut (
    .CLK_68KCLKB (CLK_68KCLKB), .nRESET (nRESET),
    .RA_STB (RA_STB), .RA_ADDR (RA_ADDR), .PA_STB (PA_STB), .PA_ADDR (PA_ADDR),
    .MODE (MODE), .rom (rom_bus),
    .RA_ACK (RA_ACK), .PA_ACK (PA_ACK), .RA_DATA (RA_DATA), .PA_DATA (PA_DATA),
    .RA_OVR (RA_OVR), .PA_OVR (PA_OVR), .BUSY (BUSY)
  );

  always #5 CLK_68KCLKB = ~CLK_68KCLKB;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK_68KCLKB);
    #1;
  endtask

  task automatic do_reset();
    nRESET = 1'b0;
    tick();
    tick();
    nRESET = 1'b1;
  endtask

  // Run ncyc edges, counting ACKs and the ROM address seen with each.
  task automatic watch(input int ncyc, output int ra_n, output int pa_n,
                       output logic [23:0] ra_a, output logic [23:0] pa_a);
    ra_n = 0; pa_n = 0; ra_a = 24'h0; pa_a = 24'h0;
    for (int c = 0; c < ncyc; c++) begin
      tick();
      check_val("ack_excl", {31'd0, RA_ACK & PA_ACK}, 32'd0);
      if (RA_ACK) begin ra_n++; ra_a = rom_bus.ROM_A; end
      if (PA_ACK) begin pa_n++; pa_a = rom_bus.ROM_A; end
    end
  endtask

  initial begin
    int ra_n, pa_n, n_ack;
    logic [23:0] ra_a, pa_a;
    RA_STB = 1'b0; PA_STB = 1'b0; RA_ADDR = 24'h0; PA_ADDR = 24'h0;
    MODE = 1'b1; rom_bus.ROM_D = 8'h00; nRESET = 1'b1;
    #1 nRESET = 1'b0;
    #2;
    check_val("rst_rom_a", {8'd0, rom_bus.ROM_A}, 32'h0);
    check_val("rst_oe", {31'd0, rom_bus.nROM_OE}, 32'd1);
    check_val("rst_misc", {24'd0, RA_ACK, PA_ACK, RA_OVR, PA_OVR, BUSY, 3'd0}, 32'h0);
    check_val("rst_data", {16'd0, RA_DATA, PA_DATA}, 32'h0);
    tick(); tick();
    nRESET = 1'b1;

    // Single RA access
    rom_bus.ROM_D = 8'hA5; RA_ADDR = 24'h123456; RA_STB = 1'b1;
    tick(); RA_STB = 1'b0;
    tick();
    check_val("single_rom_a", {8'd0, rom_bus.ROM_A}, 32'h123456);
    check_val("single_oe_k1", {31'd0, rom_bus.nROM_OE}, 32'd1);
    tick(); check_val("single_oe_k2", {31'd0, rom_bus.nROM_OE}, 32'd0);
    tick(); check_val("single_oe_k3", {31'd0, rom_bus.nROM_OE}, 32'd0);
    check_val("single_ack_k3", {31'd0, RA_ACK}, 32'd0);
    tick();
    check_val("single_oe_k4", {31'd0, rom_bus.nROM_OE}, 32'd1);
    check_val("single_ack_k4", {31'd0, RA_ACK}, 32'd1);
    check_val("single_data", {24'd0, RA_DATA}, 32'hA5);
    check_val("single_pa", {23'd0, PA_ACK, PA_DATA}, 32'h0);
    tick();
    check_val("single_ack_k5", {31'd0, RA_ACK}, 32'd0);
    check_val("single_busy_k5", {31'd0, BUSY}, 32'd0);

    // Tie after reset: RA first, PA chained without an IDLE bubble
    do_reset();
    rom_bus.ROM_D = 8'h5A; RA_ADDR = 24'h0C0001; PA_ADDR = 24'h0D0002;
    RA_STB = 1'b1; PA_STB = 1'b1;
    tick(); RA_STB = 1'b0; PA_STB = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      tick();
      check_val($sformatf("tie_ra_ack_%0d", i), {31'd0, RA_ACK}, {31'd0, i == 4});
      check_val($sformatf("tie_pa_ack_%0d", i), {31'd0, PA_ACK}, {31'd0, i == 8});
      check_val($sformatf("tie_busy_%0d", i), {31'd0, BUSY}, {31'd0, i <= 8});
      if (i == 1) check_val("tie_rom_a_ra", {8'd0, rom_bus.ROM_A}, 32'h0C0001);
      if (i == 4) rom_bus.ROM_D = 8'h77;
      if (i == 5) check_val("tie_rom_a_pa", {8'd0, rom_bus.ROM_A}, 32'h0D0002);
    end
    check_val("tie_ra_data", {24'd0, RA_DATA}, 32'h5A);
    check_val("tie_pa_data", {24'd0, PA_DATA}, 32'h77);

    // Bank decode in both modes
    MODE = 1'b0; PA_ADDR = 24'h2ABCDE; PA_STB = 1'b1;
    tick(); PA_STB = 1'b0;
    tick(); check_val("bank_mode0", {8'd0, rom_bus.ROM_A}, 32'hBABCDE);
    watch(6, ra_n, pa_n, ra_a, pa_a);
    MODE = 1'b1; PA_STB = 1'b1;
    tick(); PA_STB = 1'b0;
    tick(); check_val("bank_mode1", {8'd0, rom_bus.ROM_A}, 32'h2ABCDE);
    watch(6, ra_n, pa_n, ra_a, pa_a);

    // Overrun: two RA strobes queued behind a PA access
    rom_bus.ROM_D = 8'h3C; PA_ADDR = 24'h111111; PA_STB = 1'b1;
    tick(); PA_STB = 1'b0;
    tick(); RA_ADDR = 24'h0AAAAA; RA_STB = 1'b1;
    tick(); RA_ADDR = 24'h0BBBBB;
    tick(); RA_STB = 1'b0;
    check_val("ovr_set", {31'd0, RA_OVR}, 32'd1);
    watch(20, ra_n, pa_n, ra_a, pa_a);
    check_val("ovr_ra_count", ra_n, 32'd1);
    check_val("ovr_pa_count", pa_n, 32'd1);
    check_val("ovr_ra_addr", {8'd0, ra_a}, 32'h0AAAAA);
    check_val("ovr_pa_addr", {8'd0, pa_a}, 32'h111111);
    check_val("ovr_ra_data", {24'd0, RA_DATA}, 32'h3C);
    check_val("ovr_sticky", {30'd0, RA_OVR, PA_OVR}, 32'h2);

    // Abort an access in WAIT
    RA_ADDR = 24'h055555; RA_STB = 1'b1;
    tick(); RA_STB = 1'b0;
    tick(); tick(); tick();
    check_val("abort_in_wait", {31'd0, rom_bus.nROM_OE}, 32'd0);
    #2 nRESET = 1'b0;
    #1;
    check_val("abort_oe", {31'd0, rom_bus.nROM_OE}, 32'd1);
    check_val("abort_rom_a", {8'd0, rom_bus.ROM_A}, 32'h0);
    check_val("abort_busy", {31'd0, BUSY}, 32'd0);
    check_val("abort_ovr", {30'd0, RA_OVR, PA_OVR}, 32'h0);
    tick();
    nRESET = 1'b1;
    watch(12, ra_n, pa_n, ra_a, pa_a);
    check_val("abort_no_ack", ra_n + pa_n, 32'd0);
    check_val("abort_data", {16'd0, RA_DATA, PA_DATA}, 32'h0);
    rom_bus.ROM_D = 8'hC3; PA_ADDR = 24'h3FEDCB; PA_STB = 1'b1;
    tick(); PA_STB = 1'b0;
    watch(8, ra_n, pa_n, ra_a, pa_a);
    check_val("post_abort_pa_n", pa_n, 32'd1);
    check_val("post_abort_ra_n", ra_n, 32'd0);
    check_val("post_abort_addr", {8'd0, pa_a}, 32'h3FEDCB);
    check_val("post_abort_data", {24'd0, PA_DATA}, 32'hC3);

    // Round-robin under continuous demand (last grant was PA, so RA leads)
    RA_ADDR = 24'h000100; PA_ADDR = 24'h000200;
    RA_STB = 1'b1; PA_STB = 1'b1;
    n_ack = 0;
    for (int c = 0; c < 300 && n_ack < 10; c++) begin
      tick();
      RA_STB = 1'b0; PA_STB = 1'b0;
      check_val("rr_excl", {31'd0, RA_ACK & PA_ACK}, 32'd0);
      if (RA_ACK || PA_ACK) begin
        check_val($sformatf("rr_order_%0d", n_ack), {30'd0, RA_ACK, PA_ACK},
                  (n_ack % 2 == 1) ? 32'h1 : 32'h2);
        n_ack++;
        if (n_ack < 10) begin
          RA_STB = 1'b1; PA_STB = 1'b1;
        end
      end
    end
    check_val("rr_count", n_ack, 32'd10);
    watch(12, ra_n, pa_n, ra_a, pa_a);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pcm_rom_sched.md
# pcm_rom_sched

Sample-ROM access scheduler for the PCM subsystem. Shares one 24-bit sample ROM port between the ADPCM-A (RA) and ADPCM-B (PA) requesters, using round-robin arbitration. Each access drives the registered ROM address and asserts output-enable for a fixed wait count. It then captures the ROM byte into a per-requester data hold register and acknowledges. It sits between the sound-chip address demultiplexing and the external V-ROM bus.

## Interface
- WAIT_CYC, 2: cycles nROM_OE is held low per access; legal range 1..15.
- CLK_68KCLKB  in  1  system clock; all state updates on its rising edge.
- nRESET  in  1  asynchronous, active-low reset.
- RA_STB  in  1  one-cycle ADPCM-A request strobe.
- RA_ADDR  in  24  ADPCM-A byte address; must be stable on the strobe edge.
- PA_STB  in  1  one-cycle ADPCM-B request strobe.
- PA_ADDR  in  24  ADPCM-B byte address; must be stable on the strobe edge.
- MODE  in  1  1: ROM_A[23:20] = addr[23:20]; 0: ROM_A[23:20] = one-hot-low decode of addr[21:20].
- ROM_D  in  8  ROM read data.
- ROM_A  out  24  registered ROM address.
- nROM_OE  out  1  ROM output enable, active low.
- RA_ACK / PA_ACK  out  1 each  one-cycle done pulse.
- RA_DATA / PA_DATA  out  8 each  last byte fetched for that port; held until that port's next ACK.
- RA_OVR / PA_OVR  out  1 each  sticky overrun flag; cleared only by reset.
- BUSY  out  1  high in any state other than IDLE.

## Operation
- Per-port request slot:
  - A strobe sets `pend` and latches its address.
  - A strobe that arrives while `pend` is set (not yet granted) is dropped. It sets OVR and does not overwrite the latched address.
  - `pend` clears on grant.
  - A strobe on the grant edge sets `pend` again with the new address, giving a one-deep queue.
- Arbiter:
  - Only one port pending: that port is granted.
  - Both ports pending: grant the port not in `last`. `last` resets to PA, so RA wins the first tie.
  - `last` updates on each grant.
- FSM states: IDLE, ADDR, WAIT, CAPT.
  - IDLE: if any port is pending, grant, load ROM_A and go to ADDR. Otherwise stay.
  - ADDR: one cycle of address setup; nROM_OE stays high. Go to WAIT with wait counter = WAIT_CYC-1.
  - WAIT: nROM_OE low. While the counter is non-zero, decrement it. At zero, go to CAPT: load ROM_D into the granted port's DATA register and set its ACK.
  - CAPT: ACK high and nROM_OE high. If any port is pending, grant and go directly to ADDR (no IDLE bubble). Otherwise go to IDLE.
- Bank decode when MODE=0, on addr[21:20]: 0 -> 4'b1110, 1 -> 4'b1101, 2 -> 4'b1011, 3 -> 4'b0111.
- Address mapping: ROM_A[19:0] = addr[19:0] in both modes.

## Timing
- Reset values (asynchronous, immediate):
  - Outputs: ROM_A=0, nROM_OE=1, ACKs=0, DATA=0, OVR=0, BUSY=0.
  - Internal: `pend`=0, `last`=PA, state=IDLE.
- Reset mid-access aborts the access: no ACK is produced and DATA is unchanged from its reset value.
- Latency, strobe captured at edge k, FSM idle:
  - Grant and ROM_A valid after edge k+1.
  - nROM_OE low after edges k+2 .. k+1+WAIT_CYC.
  - ROM_D sampled, DATA loaded and ACK high at edge k+2+WAIT_CYC.
  - ACK low at edge k+3+WAIT_CYC.
- Throughput: one access per WAIT_CYC+2 cycles under continuous demand.
- ROM_A holds its value from grant until the next grant.
- ACK never asserts for both ports in the same cycle.
- DATA changes only on its own port's ACK edge.

## Structure
- Shared package pcm_pkg:
  - FSM state enum.
  - Port index constants (PORT_RA=0, PORT_PA=1).
  - Bank-decode function used by both this block and the PCM address path.
- Sub-module pcm_req_slot (strobe -> pend/address latch/overrun), instantiated once per port.
- Arbiter, FSM, wait counter and data registers live in the top module.

## Test plan
- Single request: WAIT_CYC=2, MODE=1, RA_STB with RA_ADDR=0x123456, ROM_D=0xA5. Required:
  - ROM_A=0x123456 one edge after the strobe.
  - nROM_OE low for exactly 2 cycles.
  - RA_ACK at edge k+4, RA_DATA=0xA5.
  - PA outputs untouched.
- Tie after reset: RA_STB and PA_STB on the same edge. Required:
  - RA served first.
  - PA's ADDR state follows RA's CAPT directly, with BUSY never dropping.
  - Second ACK 4 cycles after the first.
- Bank decode: MODE=0, PA_ADDR=0x2ABCDE -> ROM_A=0xBABCDE. Same address with MODE=1 -> ROM_A=0x2ABCDE.
- Overrun: two RA_STB while RA is pending behind an active PA access. Required:
  - RA_OVR=1 and stays 1.
  - Exactly one RA_ACK, carrying the first strobe's address.
- Abort: nRESET low during WAIT. Required:
  - nROM_OE=1, ROM_A=0 and BUSY=0 immediately.
  - No ACK after release.
  - A new request afterwards completes normally.
- Round-robin: both ports strobed again on every grant edge for 10 accesses -> ACKs strictly alternate RA, PA, RA, ...
